mem_access_unit: RTL and testbench

MEM-stage load/store unit directly downstream of the EX-stage ALU. Takes the ALU result as the effective address (or as pass-through result for non-memory ops), together with store data and control from EX.
Drives a req/gnt/rvalid data-memory bus with byte enables, and aligns and extends load data. Delivers one registered writeback beat per accepted instruction and stalls EX via ex_ready while a memory transaction is outstanding.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with req/gnt/rvalid bus, byte lanes and load extension.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing them.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [RD_WIDTH-1:0]   rd,
    input  logic                  reg_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [RD_WIDTH-1:0]   wb_rd,
    output logic                  wb_reg_write,
    output logic                  misalign_exc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            f3_q, f3_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic                  we_q, we_d, regw_q, regw_d;
    logic                  wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, exc_q, exc_d;

    logic                  accept, mem_op, misalign;
    logic [1:0]            a;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata, ld_word_b, ld_word_h, ld_val;

    assign accept = ex_valid & ex_ready;
    assign mem_op = mem_read | mem_write;
    assign a      = alu_result[1:0];

    // Access size from funct3[1:0]: 00 byte, 01 half, 1x (incl. unlisted codes) word.
    assign st_be    = funct3[1] ? 4'b1111 : funct3[0] ? (4'b0011 << {a[1], 1'b0}) : (4'b0001 << a);
    assign st_wdata = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = funct3[1] ? (a != 2'b00) : (funct3[0] & a[0]);
`else
    assign misalign = 1'b0;
`endif

    assign ld_word_b = dmem_rdata >> {addr_q[1:0], 3'b000};
    assign ld_word_h = dmem_rdata >> {addr_q[1], 4'b0000};
    assign ld_val    = f3_q[1] ? dmem_rdata
                     : f3_q[0] ? {{16{~f3_q[2] & ld_word_h[15]}}, ld_word_h[15:0]}
                     : {{24{~f3_q[2] & ld_word_b[7]}}, ld_word_b[7:0]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        we_d       = we_q;
        regw_d     = regw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        exc_d      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (mem_op && !misalign) begin
                    state_d = REQ;
                    addr_d  = alu_result;
                    f3_d    = funct3;
                    rd_d    = rd;
                    regw_d  = reg_write;
                    we_d    = mem_write;
                    be_d    = mem_write ? st_be : 4'b1111;
                    wdata_d = mem_write ? st_wdata : '0;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_result;
                    wb_rd_d    = rd;
                    wb_rw_d    = reg_write & ~mem_op;
                    exc_d      = mem_op;
                end
            end
            REQ: if (dmem_gnt) begin
                state_d = we_q ? IDLE : WAIT;
                if (we_q) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = 1'b0;
                end
            end
            WAIT: if (dmem_rvalid) begin
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_data_d  = ld_val;
                wb_rd_d    = rd_q;
                wb_rw_d    = regw_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            we_q       <= 1'b0;
            regw_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            regw_q     <= regw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            exc_q      <= exc_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign dmem_req     = (state_q == REQ);
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign misalign_exc = exc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the MEM-stage load/store unit.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
    logic [4:0]  rd = '0;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic        ex_ready, dmem_req, dmem_we, wb_valid, wb_reg_write, misalign_exc;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .rd(rd), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_exc(misalign_exc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Called at a negedge; presents one instruction for exactly one edge.
    task automatic issue(input logic mr, input logic mw, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] r, input logic rw);
        ex_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f;
        alu_result = a; store_data = s; rd = r; reg_write = rw;
        @(negedge clk);
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b1, 1'b0, f, a, 32'h0, 5'd7, 1'b1);
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_be"}, {28'b0, dmem_be}, 32'hF);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk({tag, "_wait_req"}, {31'b0, dmem_req}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_rw"}, {31'b0, wb_reg_write}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'b0, ex_ready}, 32'd1);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
        chk("rst_exc", {31'b0, misalign_exc}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("alu_wbv", {31'b0, wb_valid}, 32'd1);
        chk("alu_data", wb_data, 32'h0000_1234);
        chk("alu_rd", {27'b0, wb_rd}, 32'd5);
        chk("alu_rw", {31'b0, wb_reg_write}, 32'd1);
        chk("alu_ready", {31'b0, ex_ready}, 32'd1);
        @(negedge clk);
        chk("alu_wbv_drop", {31'b0, wb_valid}, 32'd0);

        issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("sb_req", {31'b0, dmem_req}, 32'd1);
            chk("sb_ready", {31'b0, ex_ready}, 32'd0);
            chk("sb_addr", dmem_addr, 32'h0000_1000);
            chk("sb_be", {28'b0, dmem_be}, 32'h8);
            chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
            chk("sb_we", {31'b0, dmem_we}, 32'd1);
            if (i == 2) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        chk("sb_wbv", {31'b0, wb_valid}, 32'd1);
        chk("sb_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("sb_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("sb_ready_back", {31'b0, ex_ready}, 32'd1);

        issue(1'b0, 1'b1, 3'b001, 32'h0000_1006, 32'h1234_BEEF, 5'd1, 1'b0);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_gnt = 1'b1; @(negedge clk); dmem_gnt = 1'b0;
        chk("sh_wbv", {31'b0, wb_valid}, 32'd1);

        // Both read and write set: the store wins.
        issue(1'b1, 1'b1, 3'b010, 32'h0000_1008, 32'hCAFE_F00D, 5'd1, 1'b1);
        chk("sw_we", {31'b0, dmem_we}, 32'd1);
        chk("sw_be", {28'b0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        dmem_gnt = 1'b1; @(negedge clk); dmem_gnt = 1'b0;
        chk("sw_rw", {31'b0, wb_reg_write}, 32'd0);

        do_load("lb", 3'b000, 32'h0000_2001, 32'h0000_8000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_2001, 32'h0000_8000, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        do_load("lh", 3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lw", 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        dmem_rvalid = 1'b1; @(negedge clk); dmem_rvalid = 1'b0;
        chk("stray_rvalid", {31'b0, wb_valid}, 32'd0);

        issue(1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0, 5'd9, 1'b1);
        dmem_gnt = 1'b1; @(negedge clk); dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, dmem_req}, 32'd0);
        chk("arst_wbv", {31'b0, wb_valid}, 32'd0);
        chk("arst_ready", {31'b0, ex_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        dmem_rvalid = 1'b1; @(negedge clk); dmem_rvalid = 1'b0;
        chk("arst_late_rvalid", {31'b0, wb_valid}, 32'd0);
        @(negedge clk);

        issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd4, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_exc", {31'b0, misalign_exc}, 32'd1);
        chk("mis_wbv", {31'b0, wb_valid}, 32'd1);
        chk("mis_rw", {31'b0, wb_reg_write}, 32'd0);
        chk("mis_ready", {31'b0, ex_ready}, 32'd1);
        @(negedge clk);
        chk("mis_exc_drop", {31'b0, misalign_exc}, 32'd0);
`else
        chk("mis_req", {31'b0, dmem_req}, 32'd1);
        chk("mis_addr", dmem_addr, 32'h0000_3000);
        chk("mis_exc", {31'b0, misalign_exc}, 32'd0);
        dmem_gnt = 1'b1; @(negedge clk); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344; @(negedge clk); dmem_rvalid = 1'b0;
        chk("mis_data", wb_data, 32'h1122_3344);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
